div_unit: RTL

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage alongside the combinational ALU, which keeps ADD..MUL. It receives the same forwarded operands a/b. Its result is muxed with the ALU result into the EX/MEM register. The pipeline stalls while the divider is busy, and a hazard flush can abort it.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the execute-stage divider
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_CALC,
      DIV_FIX,
      DIV_DONE
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic            dvd_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN:0]   shifted;
   logic [XLEN+1:0] diff;
   logic            step_unused;

   // The shifted partial remainder can reach XLEN+1 bits when the divisor has its MSB set.
   assign shifted     = {rem_in, dvd_bit};
   assign diff        = {1'b0, shifted} - {2'b00, divisor};
   assign q_bit       = ~diff[XLEN+1];
   assign rem_out     = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign step_unused = diff[XLEN] ^ shifted[XLEN];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit for the execute stage
module div_unit #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            out_valid,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   riscv_pkg::div_state_e state, state_nxt;

   logic [1:0]      op_r;
   logic [XLEN-1:0] divisor, dvd, rem;
   logic            q_neg, r_neg;
   logic [CW-1:0]   cnt;

   logic            accept, is_signed, div_zero, ovf, special;
   logic [XLEN-1:0] special_res, a_mag, b_mag, step_rem, sel_val;
   logic            q_bit, sel_neg;

   assign accept    = (state == riscv_pkg::DIV_IDLE) && in_valid && !flush;
   assign is_signed = ~op[0];
   assign div_zero  = (b == '0);
   assign ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign special   = div_zero || ovf;

   always_comb begin
      special_res = '0;
      if (div_zero) special_res = op[1] ? a : '1;
      else          special_res = op[1] ? '0 : a;
   end

   assign a_mag = (is_signed && a[XLEN-1]) ? -a : a;
   assign b_mag = (is_signed && b[XLEN-1]) ? -b : b;

   // Dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
   div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem),
      .dvd_bit (dvd[XLEN-1]),
      .divisor (divisor),
      .rem_out (step_rem),
      .q_bit   (q_bit)
   );

   assign sel_val = op_r[1] ? rem : dvd;
   assign sel_neg = op_r[1] ? r_neg : q_neg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= riscv_pkg::DIV_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state)
         riscv_pkg::DIV_IDLE: begin
            in_ready = 1'b1;
            if (accept) state_nxt = special ? riscv_pkg::DIV_DONE : riscv_pkg::DIV_CALC;
         end
         riscv_pkg::DIV_CALC: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = riscv_pkg::DIV_FIX;
         end
         riscv_pkg::DIV_FIX: begin
            busy      = 1'b1;
            state_nxt = riscv_pkg::DIV_DONE;
         end
         riscv_pkg::DIV_DONE: begin
            out_valid = !flush;
            state_nxt = riscv_pkg::DIV_IDLE;
         end
         default: state_nxt = riscv_pkg::DIV_IDLE;
      endcase
      if (flush) state_nxt = riscv_pkg::DIV_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r    <= '0;
         divisor <= '0;
         dvd     <= '0;
         rem     <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         cnt     <= '0;
         result  <= '0;
      end else begin
         case (state)
            riscv_pkg::DIV_IDLE: begin
               if (accept) begin
                  op_r    <= op;
                  q_neg   <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
                  r_neg   <= is_signed & a[XLEN-1];
                  dvd     <= a_mag;
                  divisor <= b_mag;
                  rem     <= '0;
                  cnt     <= CW'(XLEN-1);
                  if (special) result <= special_res;
               end
            end
            riscv_pkg::DIV_CALC: begin
               if (!flush) begin
                  rem <= step_rem;
                  dvd <= {dvd[XLEN-2:0], q_bit};
                  cnt <= cnt - 1'b1;
               end
            end
            riscv_pkg::DIV_FIX: begin
               if (!flush) result <= sel_neg ? -sel_val : sel_val;
            end
            default: ;
         endcase
      end
   end

endmodule
